// File: rtl/stack_pkg.sv
// Shared constants for the stack sequencer: op codes, SP register index, word size, FSM states.
// Pure declarations; no latency and no flow control.
package stack_pkg;

    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_POP  = 2'b01,
        OP_CALL = 2'b10,
        OP_RET  = 2'b11
    } op_e;

    localparam logic [4:0]  SP_INDEX   = 5'd16;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_MEM,
        S_WB_REG,
        S_WB_SP,
        S_DONE
    } state_e;

endpackage

// File: rtl/stack_ctrl.sv
// Stack sequencer for PUSH/POP/CALL/RET: reads SP and an operand, does one memory access, writes back.
// done 4-5 cycles after start plus memory wait cycles; holds the request stable until mem_ready, drops start while busy.
module stack_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [4:0]  reg_sel,
    input  logic [31:0] ret_pc,
    input  logic [31:0] call_target,
    output logic        busy,
    output logic        done,
    output logic        pc_load,
    output logic [31:0] new_pc,
    output logic [4:0]  readport1,
    output logic [4:0]  readport2,
    output logic        RegRead,
    input  logic [31:0] regA,
    input  logic [31:0] regB,
    output logic [4:0]  writeport,
    output logic [31:0] writedata,
    output logic        RegWrite,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);
    import stack_pkg::*;

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [4:0]  sel_q, sel_d;
    logic [31:0] ret_pc_q, ret_pc_d;
    logic [31:0] target_q, target_d;
    logic [31:0] sp_q, sp_d;
    logic [31:0] opnd_q, opnd_d;
    logic [31:0] data_q, data_d;

    logic        grows;
    logic [31:0] sp_adj;

    // One adder serves both the pre-decrement address and the SP writeback.
    assign grows  = (op_q == OP_PUSH) || (op_q == OP_CALL);
    assign sp_adj = grows ? (sp_q - WORD_BYTES) : (sp_q + WORD_BYTES);
    assign busy   = (state_q != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_PUSH;
            sel_q    <= '0;
            ret_pc_q <= '0;
            target_q <= '0;
            sp_q     <= '0;
            opnd_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sel_q    <= sel_d;
            ret_pc_q <= ret_pc_d;
            target_q <= target_d;
            sp_q     <= sp_d;
            opnd_q   <= opnd_d;
            data_q   <= data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        sel_d     = sel_q;
        ret_pc_d  = ret_pc_q;
        target_d  = target_q;
        sp_d      = sp_q;
        opnd_d    = opnd_q;
        data_d    = data_q;
        done      = 1'b0;
        pc_load   = 1'b0;
        new_pc    = '0;
        readport1 = '0;
        readport2 = '0;
        RegRead   = 1'b0;
        writeport = '0;
        writedata = '0;
        RegWrite  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d     = op_e'(op);
                    sel_d    = reg_sel;
                    ret_pc_d = ret_pc;
                    target_d = call_target;
                    state_d  = S_READ;
                end
            end
            S_READ: begin
                RegRead   = 1'b1;
                readport1 = SP_INDEX;
                readport2 = sel_q;
                sp_d      = regA;
                opnd_d    = regB;
                state_d   = S_MEM;
            end
            S_MEM: begin
                if (grows) begin
                    mem_addr = sp_adj;
                    mem_we   = 1'b1;
                    // Pushing SP stores its value before the decrement.
                    if (op_q == OP_CALL)
                        mem_wdata = ret_pc_q;
                    else
                        mem_wdata = sel_q[4] ? sp_q : opnd_q;
                end else begin
                    mem_addr = sp_q;
                    mem_re   = 1'b1;
                end
                if (mem_ready) begin
                    data_d = mem_rdata;
                    if (op_q == OP_POP && sel_q != 5'd0)
                        state_d = S_WB_REG;
                    else
                        state_d = S_WB_SP;
                end
            end
            S_WB_REG: begin
                writeport = sel_q;
                writedata = data_q;
                RegWrite  = 1'b1;
                // Popping into SP replaces it outright, so the increment is skipped.
                state_d   = sel_q[4] ? S_DONE : S_WB_SP;
            end
            S_WB_SP: begin
                writeport = SP_INDEX;
                writedata = sp_adj;
                RegWrite  = 1'b1;
                state_d   = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (op_q == OP_CALL) begin
                    pc_load = 1'b1;
                    new_pc  = target_q;
                end else if (op_q == OP_RET) begin
                    pc_load = 1'b1;
                    new_pc  = data_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Sequencer that drives the register bank's read/write ports and a word-addressed data-memory port to execute stack operations: PUSH, POP, CALL and RET. It reads SP (register index 16) and an operand register, issues one memory access, then writes SP and/or the destination register back. It sits between the control unit, the register bank and data memory, and owns those ports only while `busy` is high.

## Interface
- No parameters; constants come from `stack_pkg`.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request; sampled only in IDLE.
- `op` in 2: operation; 00 PUSH, 01 POP, 10 CALL, 11 RET.
- `reg_sel` in 5: PUSH source / POP destination; 16–31 all mean SP.
- `ret_pc` in 32: return address pushed by CALL.
- `call_target` in 32: jump target for CALL.
- `busy` out 1: high from the cycle after accepted `start` through DONE.
- `done` out 1: one-cycle pulse in DONE.
- `pc_load` out 1: high with `done` for CALL/RET only.
- `new_pc` out 32: `call_target` (CALL) or popped word (RET); valid while `pc_load`=1.
- `readport1`, `readport2` out 5: register read indices.
- `RegRead` out 1: register read enable.
- `regA`, `regB` in 32: register read data, combinational from the bank.
- `writeport` out 5, `writedata` out 32, `RegWrite` out 1: register write port, committed at the next clock edge.
- `mem_addr` out 32, `mem_wdata` out 32, `mem_we` out 1, `mem_re` out 1: memory request.
- `mem_rdata` in 32, `mem_ready` in 1: memory response; the access completes in the cycle `mem_ready`=1.

## Operation
- States: IDLE, READ, MEM, WB_REG, WB_SP, DONE.
- IDLE: when `start`=1, latch `op`, `reg_sel`, `ret_pc` and `call_target`, then go to READ. Any other input is ignored.
- READ: drive `RegRead`=1, `readport1`=16 and `readport2`=`reg_sel`. Latch `sp_q`=`regA` and `opnd_q`=`regB`, then go to MEM.
- Address rule: stack grows downward in 4-byte words. PUSH and CALL pre-decrement; POP and RET post-increment. Arithmetic is modulo 2^32 with no overflow or underflow detection.
- MEM:
  - PUSH: `mem_addr`=`sp_q`−4, `mem_wdata`=`opnd_q`, `mem_we`=1.
  - CALL: same as PUSH but `mem_wdata`=`ret_pc`.
  - POP and RET: `mem_addr`=`sp_q`, `mem_re`=1.
  - Request signals stay stable until `mem_ready`. On `mem_ready`, latch `mem_rdata` into `data_q` and go to the next state.
- Next state after MEM:
  - PUSH and CALL go to WB_SP.
  - POP goes to WB_REG, except POP with `reg_sel`=0 goes to WB_SP.
  - RET goes to WB_SP.
- WB_REG: `writeport`=`reg_sel`, `writedata`=`data_q`, `RegWrite`=1.
  - If `reg_sel`≥16, the popped value becomes SP and the state goes directly to DONE with no increment.
  - Otherwise the state goes to WB_SP.
- WB_SP: `writeport`=16, `RegWrite`=1, `writedata`=`sp_q`−4 (PUSH/CALL) or `sp_q`+4 (POP/RET). Then go to DONE.
- DONE:
  - Assert `done`.
  - CALL: `pc_load`=1, `new_pc`=`call_target`.
  - RET: `pc_load`=1, `new_pc`=`data_q`.
  - Return to IDLE.
- PUSH of SP (`reg_sel`≥16) stores the pre-decrement SP value.
- All request outputs (`RegRead`, `RegWrite`, `mem_we`, `mem_re`) are 0 outside their states. Indices and data are 0 when unused.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE; every output 0; latched registers 0. An in-flight memory request is dropped immediately and never retried.
- `start` accepted at edge 0: READ in cycle 1, MEM in cycle 2.
- With `mem_ready`=1 in the first MEM cycle:
  - PUSH and CALL: `done` in cycle 4.
  - POP (`reg_sel` 1–15): `done` in cycle 5.
  - POP to 0 or to SP: `done` in cycle 4.
  - RET: `done` in cycle 4.
- Each MEM wait cycle adds one cycle of latency.
- Back-to-back: a new `start` is accepted in the cycle after DONE, in IDLE. `start` during `busy` is dropped.
- The register bank reads combinationally, so READ needs exactly one cycle. Writes land at the clock edge ending WB_*.

## Structure
- `stack_pkg` holds:
  - op encodings `OP_PUSH`, `OP_POP`, `OP_CALL`, `OP_RET`;
  - `SP_INDEX`=5'd16;
  - `WORD_BYTES`=4;
  - the state enum.
- No sub-module: one FSM plus a single ±4 adder on `sp_q`.

## Test plan
- Reset with bank SP=0xFFFFFFFC, R5=5; PUSH `reg_sel`=5 with `mem_ready` tied high -> `mem_we` in cycle 2 with addr 0xFFFFFFF8, data 5; SP=0xFFFFFFF8; `done` in cycle 4.
- Follow with POP `reg_sel`=7 -> `mem_re` at 0xFFFFFFF8; R7=5; SP=0xFFFFFFFC; `done` in cycle 5.
- CALL with `ret_pc`=0x104, `call_target`=0x200, then RET -> push 0x104 at 0xFFFFFFF8; `pc_load` with `new_pc`=0x200, then `pc_load` with `new_pc`=0x104; SP restored to 0xFFFFFFFC.
- PUSH with `mem_ready` held low for 3 cycles -> `mem_addr`, `mem_wdata` and `mem_we` stable throughout; `done` in cycle 7; `start` pulses during `busy` ignored.
- SP=0x00000000, PUSH R1=1 -> write at 0xFFFFFFFC, SP=0xFFFFFFFC (wrap); POP `reg_sel`=16 -> SP loaded with the popped word, no increment.
- `rst` driven low in MEM while `mem_we`=1 -> all outputs 0 immediately with no clock edge; no RegWrite occurs; the next `start` runs normally.
